// File: rtl/sa_pkg.sv
// Shared types and constants for the round-robin system agent.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sa_state_e;

  localparam int MEM_LAT_MAX = 8;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX);
  localparam int PERF_CNT_W  = 32;

  // A single channel still needs a 1-bit pointer register.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping modulo N_CH.
module rr_arbiter
  import sa_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int PW  = ptr_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [N_CH-1:0] gnt_oh,
  output logic [PW-1:0]   gnt_idx,
  output logic            any_req
);

  logic          found;
  logic [PW-1:0] cidx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cidx    = '0;
    for (int k = 0; k < N_CH; k++) begin
      cidx = PW'((int'(rr_ptr) + k) % N_CH);
      if (!found && req[cidx]) begin
        found        = 1'b1;
        gnt_oh[cidx] = 1'b1;
        gnt_idx      = cidx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/sys_agent_rr.sv
// Round-robin agent: N_CH request channels onto one synchronous memory port, one transaction in flight.
// Optional per-channel grant counters are built when SA_PERF_CNT_EN is defined.
module sys_agent_rr
  import sa_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int IDW     = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            ch_req,
  input  logic [N_CH-1:0]            ch_we,
  input  logic [N_CH*AW-1:0]         ch_addr,
  input  logic [N_CH*DW-1:0]         ch_wdata,
  input  logic [N_CH*IDW-1:0]        ch_tid,
  output logic [N_CH-1:0]            ch_gnt,
  output logic [N_CH-1:0]            ch_rsp_valid,
  output logic [DW-1:0]              ch_rsp_data,
  output logic [IDW-1:0]             ch_rsp_tid,
  output logic                       mem_cs,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata,
  output logic [N_CH*PERF_CNT_W-1:0] perf_gnt_cnt
);

  localparam int PW = ptr_w(N_CH);

  sa_state_e            state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        win_q, win_d;
  logic                 we_lat_q, we_lat_d;
  logic [IDW-1:0]       tid_lat_q, tid_lat_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic [N_CH-1:0]      gnt_q, gnt_d;
  logic [N_CH-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]        rsp_data_q, rsp_data_d;
  logic [IDW-1:0]       rsp_tid_q, rsp_tid_d;
  logic                 mem_cs_q, mem_cs_d;
  logic                 mem_we_q, mem_we_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;

  logic [N_CH-1:0]      arb_oh;
  logic [PW-1:0]        arb_idx;
  logic                 arb_any;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (ch_req),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  // Outputs are registered, so each strobe is computed in the cycle before the state that shows it.
  // WAIT spans MEM_LAT cycles; its last cycle is the one where mem_rdata is valid.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    we_lat_d    = we_lat_q;
    tid_lat_d   = tid_lat_q;
    lat_cnt_d   = lat_cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_tid_d   = '0;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d     = ISSUE;
          win_d       = arb_idx;
          we_lat_d    = ch_we[arb_idx];
          tid_lat_d   = ch_tid[arb_idx*IDW +: IDW];
          gnt_d       = arb_oh;
          mem_cs_d    = 1'b1;
          mem_we_d    = ch_we[arb_idx];
          mem_addr_d  = ch_addr[arb_idx*AW +: AW];
          mem_wdata_d = ch_wdata[arb_idx*DW +: DW];
          rr_ptr_d    = (int'(arb_idx) == N_CH - 1) ? '0 : arb_idx + PW'(1);
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        lat_cnt_d = LAT_CNT_W'(MEM_LAT - 1);
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = N_CH'(1) << win_q;
          rsp_tid_d   = tid_lat_q;
          rsp_data_d  = we_lat_q ? '0 : mem_rdata;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      we_lat_q    <= 1'b0;
      tid_lat_q   <= '0;
      lat_cnt_q   <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_tid_q   <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      we_lat_q    <= we_lat_d;
      tid_lat_q   <= tid_lat_d;
      lat_cnt_q   <= lat_cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tid_q   <= rsp_tid_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ch_gnt       = gnt_q;
  assign ch_rsp_valid = rsp_valid_q;
  assign ch_rsp_data  = rsp_data_q;
  assign ch_rsp_tid   = rsp_tid_q;
  assign mem_cs       = mem_cs_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

`ifdef SA_PERF_CNT_EN
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_perf
    logic [PERF_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (gnt_q[gi] && (cnt_q != '1)) begin
        cnt_d = cnt_q + PERF_CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign perf_gnt_cnt[gi*PERF_CNT_W +: PERF_CNT_W] = cnt_q;
  end
`else
  assign perf_gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_sys_agent_rr.sv
// Directed bench for sys_agent_rr: a MEM_LAT=1 and a MEM_LAT=3 instance, each with its own memory model.
module tb_sys_agent_rr;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel3;
  logic [3:0]   ch_req, ch_we;
  logic [63:0]  ch_addr;
  logic [127:0] ch_wdata;
  logic [15:0]  ch_tid;
  logic [3:0]   req1, req3;

  logic [3:0]   gnt1, rspv1, gnt3, rspv3;
  logic [31:0]  rspd1, rspd3, wd1, wd3, rdata1, rdata3;
  logic [3:0]   rspt1, rspt3;
  logic         cs1, we1, cs3, we3;
  logic [15:0]  addr1, addr3;
  logic [127:0] perf1, perf3;

  logic [3:0]   o_gnt, o_rspv, o_rspt;
  logic [31:0]  o_rspd, o_wd;
  logic         o_cs, o_we;
  logic [15:0]  o_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign req1   = sel3 ? 4'b0 : ch_req;
  assign req3   = sel3 ? ch_req : 4'b0;
  assign o_gnt  = sel3 ? gnt3  : gnt1;
  assign o_rspv = sel3 ? rspv3 : rspv1;
  assign o_rspd = sel3 ? rspd3 : rspd1;
  assign o_rspt = sel3 ? rspt3 : rspt1;
  assign o_cs   = sel3 ? cs3   : cs1;
  assign o_we   = sel3 ? we3   : we1;
  assign o_addr = sel3 ? addr3 : addr1;
  assign o_wd   = sel3 ? wd3   : wd1;

  sys_agent_rr #(.N_CH(4), .AW(16), .DW(32), .IDW(4), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ch_req(req1), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_tid(ch_tid), .ch_gnt(gnt1), .ch_rsp_valid(rspv1),
    .ch_rsp_data(rspd1), .ch_rsp_tid(rspt1), .mem_cs(cs1), .mem_we(we1),
    .mem_addr(addr1), .mem_wdata(wd1), .mem_rdata(rdata1), .perf_gnt_cnt(perf1)
  );

  sys_agent_rr #(.N_CH(4), .AW(16), .DW(32), .IDW(4), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ch_req(req3), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_tid(ch_tid), .ch_gnt(gnt3), .ch_rsp_valid(rspv3),
    .ch_rsp_data(rspd3), .ch_rsp_tid(rspt3), .mem_cs(cs3), .mem_we(we3),
    .mem_addr(addr3), .mem_wdata(wd3), .mem_rdata(rdata3), .perf_gnt_cnt(perf3)
  );

  // Memory models: read data is only driven in the cycle it is due, garbage otherwise.
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic        rv1;
  logic [31:0] rd1;
  logic        rv3 [0:2];
  logic [31:0] rd3 [0:2];

  always @(posedge clk) begin
    rv1 <= cs1 && !we1;
    rd1 <= mem1[addr1[9:0]];
    if (!rst_n) begin
      mem1[10'h010] <= 32'hDEAD_BEEF;
      mem1[10'h104] <= 32'hA1A1_0104;
      mem1[10'h200] <= 32'hC0C0_0200;
      mem1[10'h208] <= 32'hC2C2_0208;
      mem1[10'h300] <= 32'h3030_0300;
    end else if (cs1 && we1) begin
      mem1[addr1[9:0]] <= wd1;
    end
  end
  assign rdata1 = rv1 ? rd1 : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    rv3[0] <= cs3 && !we3;
    rd3[0] <= mem3[addr3[9:0]];
    rv3[1] <= rv3[0];
    rd3[1] <= rd3[0];
    rv3[2] <= rv3[1];
    rd3[2] <= rd3[1];
    if (cs3 && we3) mem3[addr3[9:0]] <= wd3;
  end
  assign rdata3 = rv3[2] ? rd3[2] : 32'hBAD0_BAD0;

  typedef struct {
    logic         rst;
    logic         sel3;
    logic [3:0]   req;
    logic [3:0]   we;
    logic [63:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  tid;
    int           dly;
    logic [3:0]   e_gnt;
    logic         e_we;
    logic [15:0]  e_addr;
    logic [31:0]  e_wdata;
    logic [31:0]  e_data;
    logic [3:0]   e_tid;
  } vec_t;

  localparam logic [63:0]  A_ADDR = {16'h0300, 16'h0010, 16'h0104, 16'h0100};
  localparam logic [127:0] A_WD   = {32'h3, 32'h2, 32'h1, 32'h0};
  localparam logic [15:0]  A_TID  = {4'd3, 4'd5, 4'd1, 4'd0};
  localparam logic [63:0]  B_ADDR = {16'h020C, 16'h0208, 16'h0204, 16'h0200};
  localparam logic [127:0] B_WD   = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0};
  localparam logic [15:0]  B_TID  = {4'd11, 4'd10, 4'd9, 4'd8};
  localparam logic [63:0]  C_ADDR = {48'h0, 16'h0004};
  localparam logic [127:0] C_WD   = {96'h0, 32'h1234_5678};

  vec_t tbl [10];

  function automatic vec_t mk(input logic rst, input logic s3, input logic [3:0] req, input logic [3:0] we,
                              input logic [63:0] addr, input logic [127:0] wd, input logic [15:0] tid,
                              input int dly, input logic [3:0] eg, input logic ewe, input logic [15:0] ea,
                              input logic [31:0] ewd, input logic [31:0] ed, input logic [3:0] et);
    vec_t v;
    v.rst = rst; v.sel3 = s3; v.req = req; v.we = we; v.addr = addr; v.wdata = wd; v.tid = tid;
    v.dly = dly; v.e_gnt = eg; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd; v.e_data = ed; v.e_tid = et;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ch_req = '0;
    repeat (2) @(negedge clk);
    chk("rst_dut1_ctl", {56'h0, gnt1, rspv1}, 64'h0);
    chk("rst_dut1_mem", {14'h0, cs1, we1, addr1, wd1}, 64'h0);
    chk("rst_dut1_rsp", {28'h0, rspd1, rspt1}, 64'h0);
    chk("rst_dut3_ctl", {14'h0, cs3, we3, gnt3, rspv3, rspt3, addr3, 4'h0}, 64'h0);
    chk("rst_dut3_data", {rspd3, wd3}, 64'h0);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   n;
    int   lat;
    logic got;
    lat = v.sel3 ? 3 : 1;
    if (v.rst) do_reset();
    sel3     = v.sel3;
    ch_we    = v.we;
    ch_addr  = v.addr;
    ch_wdata = v.wdata;
    ch_tid   = v.tid;
    ch_req   = v.req;
    n   = 0;
    got = 1'b0;
    while (!got && n < 4) begin
      @(negedge clk);
      n++;
      got = |o_gnt;
    end
    chk("gnt_delay", 64'(n), 64'(v.dly));
    chk("gnt", 64'(o_gnt), 64'(v.e_gnt));
    chk("issue_cs_we", {62'h0, o_cs, o_we}, {62'h0, 1'b1, v.e_we});
    chk("issue_addr", 64'(o_addr), 64'(v.e_addr));
    chk("issue_wdata", 64'(o_wd), 64'(v.e_wdata));
    ch_req = '0;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      chk("wait_quiet", {52'h0, o_gnt, o_rspv, 3'b0, o_cs}, 64'h0);
    end
    @(negedge clk);
    chk("rsp_valid", 64'(o_rspv), 64'(v.e_gnt));
    chk("rsp_data", 64'(o_rspd), 64'(v.e_data));
    chk("rsp_tid", 64'(o_rspt), 64'(v.e_tid));
    $display("txn %0d lat=%0d gnt=%b rsp_valid=%b data=%h tid=%0d", idx, lat, v.e_gnt, o_rspv, o_rspd, o_rspt);
  endtask

  initial begin
    rst_n = 1'b0; sel3 = 1'b0; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0; ch_tid = '0;

    // single read, then skip idle channels from rr_ptr=3
    tbl[0] = mk(1, 0, 4'b0100, 4'b0000, A_ADDR, A_WD, A_TID, 1, 4'b0100, 0, 16'h0010, 32'h2, 32'hDEAD_BEEF, 4'd5);
    tbl[1] = mk(0, 0, 4'b0110, 4'b0000, A_ADDR, A_WD, A_TID, 2, 4'b0010, 0, 16'h0104, 32'h1, 32'hA1A1_0104, 4'd1);
    tbl[2] = mk(0, 0, 4'b0100, 4'b0000, A_ADDR, A_WD, A_TID, 2, 4'b0100, 0, 16'h0010, 32'h2, 32'hDEAD_BEEF, 4'd5);
    // all four requesting from reset
    tbl[3] = mk(1, 0, 4'b1111, 4'b1010, B_ADDR, B_WD, B_TID, 1, 4'b0001, 0, 16'h0200, 32'h0, 32'hC0C0_0200, 4'd8);
    tbl[4] = mk(0, 0, 4'b1111, 4'b1010, B_ADDR, B_WD, B_TID, 2, 4'b0010, 1, 16'h0204, 32'h1111_0001, 32'h0, 4'd9);
    tbl[5] = mk(0, 0, 4'b1111, 4'b1010, B_ADDR, B_WD, B_TID, 2, 4'b0100, 0, 16'h0208, 32'h2222_0002, 32'hC2C2_0208, 4'd10);
    tbl[6] = mk(0, 0, 4'b1111, 4'b1010, B_ADDR, B_WD, B_TID, 2, 4'b1000, 1, 16'h020C, 32'h3333_0003, 32'h0, 4'd11);
    tbl[7] = mk(0, 0, 4'b1111, 4'b1010, B_ADDR, B_WD, B_TID, 2, 4'b0001, 0, 16'h0200, 32'h0, 32'hC0C0_0200, 4'd8);
    // MEM_LAT=3: write then read back
    tbl[8] = mk(0, 1, 4'b0001, 4'b0001, C_ADDR, C_WD, 16'h0001, 1, 4'b0001, 1, 16'h0004, 32'h1234_5678, 32'h0, 4'd1);
    tbl[9] = mk(0, 1, 4'b0001, 4'b0000, C_ADDR, C_WD, 16'h0002, 2, 4'b0001, 0, 16'h0004, 32'h1234_5678, 32'h1234_5678, 4'd2);

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // reset during WAIT aborts the transaction and restarts arbitration at index 0
    do_reset();
    sel3 = 1'b0; ch_we = '0; ch_addr = A_ADDR; ch_wdata = A_WD; ch_tid = A_TID;
    ch_req = 4'b0010;
    @(negedge clk);
    chk("abort_gnt", 64'(gnt1), 64'h2);
    ch_req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_quiet", {55'h0, gnt1, rspv1, cs1}, 64'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_rsp", {59'h0, rspv1, cs1}, 64'h0);
    end
    ch_req = 4'b1010;
    @(negedge clk);
    chk("post_abort_gnt", 64'(gnt1), 64'h2);
    ch_req = '0;
    repeat (2) @(negedge clk);
    chk("post_abort_rsp", {rspd1, 24'h0, rspv1, rspt1}, {32'hA1A1_0104, 24'h0, 4'b0010, 4'd1});
    $display("txn abort rsp_valid=%b data=%h tid=%0d", rspv1, rspd1, rspt1);

`ifdef SA_PERF_CNT_EN
    for (int i = 0; i < 5; i++) begin
      run_vec(20 + i, mk(i == 0, 0, 4'b1000, 4'b0000, A_ADDR, A_WD, A_TID, (i == 0) ? 1 : 2,
                         4'b1000, 0, 16'h0300, 32'h3, 32'h3030_0300, 4'd3));
    end
    chk("perf_ch3", 64'(perf1[127:96]), 64'd5);
    chk("perf_ch0_2", 64'(perf1[95:0] != 96'h0), 64'h0);
    force dut1.g_perf[3].cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut1.g_perf[3].cnt_q;
    run_vec(25, mk(0, 0, 4'b1000, 4'b0000, A_ADDR, A_WD, A_TID, 1,
                   4'b1000, 0, 16'h0300, 32'h3, 32'h3030_0300, 4'd3));
    chk("perf_sat", 64'(perf1[127:96]), 64'hFFFF_FFFF);
`else
    chk("perf_off_dut1", 64'(perf1 != 128'h0), 64'h0);
    chk("perf_off_dut3", 64'(perf3 != 128'h0), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
